// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state type, requester count and saturating counter helper
package imem_pkg;
  localparam int N_REQ = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin select; ports req (requests), last (previous winner), gnt (one-hot grant)
module rr_arb2
  import imem_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  output logic [N_REQ-1:0] gnt
);
  // on contention the requester that did not win last time goes next
  always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/input_mem_read_arbiter.sv
// input_mem_read_arbiter: two-requester read port arbiter in front of a 1-cycle-latency memory; ports: clk, rst (async active-low), req_valid/req_addr0/req_addr1/req_ready, resp_valid/resp_data/resp_ready, mem_rd_en/mem_addr/mem_rdata, grant_cnt0/grant_cnt1
module input_mem_read_arbiter
  import imem_pkg::*;
#(
  parameter int ADD_SIZE  = 12,
  parameter int DATA_SIZE = 108
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [ADD_SIZE-1:0]  req_addr0,
  input  logic [ADD_SIZE-1:0]  req_addr1,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [DATA_SIZE-1:0] resp_data,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic                 mem_rd_en,
  output logic [ADD_SIZE-1:0]  mem_addr,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1
);
  state_t state, state_nxt;
  logic [N_REQ-1:0] gnt;
  logic [15:0] cnt0, cnt1;
  logic last_grant, idx, grant;
  rr_arb2 u_arb (.req(req_valid), .last(last_grant), .gnt(gnt));
  assign grant = (state == IDLE) && |req_valid;
  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE)    ? (grant ? ISSUE : IDLE) :
                (state == ISSUE)   ? CAPTURE :
                (state == CAPTURE) ? RESP :
                (resp_ready[idx] ? IDLE : RESP);
  always_comb begin
    req_ready  = (state == IDLE) ? gnt : 2'b00;
    resp_valid = (state == RESP) ? {idx, ~idx} : 2'b00;
    mem_rd_en  = (state == ISSUE);
  end
  // mem_addr doubles as the latched request address and holds between reads
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx        <= 1'b0;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      resp_data  <= '0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      if (grant) begin
        idx        <= gnt[1];
        last_grant <= gnt[1];
        mem_addr   <= gnt[1] ? req_addr1 : req_addr0;
        if (gnt[0]) cnt0 <= sat_inc(cnt0);
        if (gnt[1]) cnt1 <= sat_inc(cnt1);
      end
      if (state == CAPTURE) resp_data <= mem_rdata;
    end
endmodule

// File: tb/tb_input_mem_read_arbiter.sv
// tb_input_mem_read_arbiter: directed self-checking bench for input_mem_read_arbiter
module tb_input_mem_read_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [11:0]  req_addr0, req_addr1;
  logic [1:0]   req_ready, resp_valid, resp_ready;
  logic [107:0] resp_data, mem_rdata;
  logic         mem_rd_en;
  logic [11:0]  mem_addr;
  logic [15:0]  grant_cnt0, grant_cnt1;
  int errors = 0;
  int checks = 0;
  input_mem_read_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic serve(input logic [1:0] rv, input logic [107:0] d,
                       output logic [1:0] won, output logic [1:0] obs_v, output logic [107:0] obs_d);
    req_valid = rv;
    #1;
    won = req_ready;
    tick();
    req_valid = 2'b00;
    tick();
    mem_rdata = d;
    tick();
    mem_rdata = '1;
    obs_v = resp_valid;
    obs_d = resp_data;
    resp_ready = won;
    tick();
    resp_ready = 2'b00;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    req_valid = 2'b00; req_addr0 = '0; req_addr1 = '0; resp_ready = 2'b00; mem_rdata = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({req_ready, resp_valid, mem_rd_en} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want 00000", {req_ready, resp_valid, mem_rd_en}); end
    checks++; if (mem_addr !== 12'h0 || resp_data !== 108'h0) begin errors++; $display("FAIL reset_data: got addr=%h data=%h want 0", mem_addr, resp_data); end
    checks++; if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", grant_cnt0, grant_cnt1); end
    rst = 1'b1;
    tick();
  endtask
  task automatic test_single();
    req_addr0 = 12'h123; req_addr1 = 12'h456;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_accept: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 12'h123) begin errors++; $display("FAIL single_issue: got en=%b addr=%h want 1/123", mem_rd_en, mem_addr); end
    checks++; if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin errors++; $display("FAIL single_issue_hs: got rdy=%b rv=%b want 00/00", req_ready, resp_valid); end
    tick();
    mem_rdata = 108'hABC;
    checks++; if (mem_rd_en !== 1'b0 || resp_valid !== 2'b00 || mem_addr !== 12'h123) begin errors++; $display("FAIL single_capture: got en=%b rv=%b addr=%h want 0/00/123", mem_rd_en, resp_valid, mem_addr); end
    tick();
    mem_rdata = '1;
    checks++; if (resp_valid !== 2'b01 || resp_data !== 108'hABC) begin errors++; $display("FAIL single_resp: got rv=%b data=%h want 01/abc", resp_valid, resp_data); end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    checks++; if (resp_valid !== 2'b00 || grant_cnt0 !== 16'd1 || grant_cnt1 !== 16'd0) begin errors++; $display("FAIL single_done: got rv=%b cnt=%0d/%0d want 00 1/0", resp_valid, grant_cnt0, grant_cnt1); end
  endtask
  task automatic test_contention();
    logic [1:0] won, ov;
    logic [107:0] od;
    logic [1:0] exp_w [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    req_addr0 = 12'h0A0; req_addr1 = 12'h0B1;
    for (int i = 0; i < 4; i++) begin
      serve(2'b11, 108'h100 + 108'(i), won, ov, od);
      checks++; if (won !== exp_w[i] || ov !== exp_w[i] || od !== 108'h100 + 108'(i)) begin errors++; $display("FAIL contention_%0d: got gnt=%b rv=%b data=%h want %b/%b/%h", i, won, ov, od, exp_w[i], exp_w[i], 108'h100 + 108'(i)); end
    end
    checks++; if (grant_cnt0 !== 16'd2 || grant_cnt1 !== 16'd2) begin errors++; $display("FAIL contention_cnt: got %0d/%0d want 2/2", grant_cnt0, grant_cnt1); end
    checks++; if (mem_addr !== 12'h0B1) begin errors++; $display("FAIL contention_addr: got %h want 0b1", mem_addr); end
  endtask
  task automatic test_backpressure();
    req_addr1 = 12'h777;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b11;
    tick();
    mem_rdata = 108'h5A5A5;
    tick();
    mem_rdata = '1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 2'b10 || resp_data !== 108'h5A5A5 || mem_rd_en !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL backpressure_%0d: got rv=%b data=%h en=%b rdy=%b want 10/5a5a5/0/00", i, resp_valid, resp_data, mem_rd_en, req_ready); end
      tick();
    end
    resp_ready = 2'b10;
    req_valid = 2'b00;
    tick();
    resp_ready = 2'b00;
    checks++; if (resp_valid !== 2'b00 || grant_cnt1 !== 16'd3) begin errors++; $display("FAIL backpressure_done: got rv=%b cnt1=%0d want 00/3", resp_valid, grant_cnt1); end
  endtask
  task automatic test_wrong_port();
    req_addr0 = 12'h321;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    mem_rdata = 108'hC0FFEE;
    tick();
    mem_rdata = '1;
    resp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (resp_valid !== 2'b01 || resp_data !== 108'hC0FFEE) begin errors++; $display("FAIL wrong_port_%0d: got rv=%b data=%h want 01/c0ffee", i, resp_valid, resp_data); end
    end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL wrong_port_release: got rv=%b want 00", resp_valid); end
  endtask
  task automatic test_mid_reset();
    logic [1:0] won, ov;
    logic [107:0] od;
    req_addr0 = 12'h3C5;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    mem_rdata = 108'hDEAD;
    #3;
    rst = 1'b0;
    #1;
    checks++; if ({req_ready, resp_valid, mem_rd_en} !== 5'b0 || mem_addr !== 12'h0 || resp_data !== 108'h0) begin errors++; $display("FAIL midreset_out: got ctl=%b addr=%h data=%h want 0", {req_ready, resp_valid, mem_rd_en}, mem_addr, resp_data); end
    checks++; if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin errors++; $display("FAIL midreset_cnt: got %h/%h want 0/0", grant_cnt0, grant_cnt1); end
    tick();
    rst = 1'b1;
    mem_rdata = '1;
    tick();
    tick();
    checks++; if (resp_valid !== 2'b00 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL midreset_abandon: got rv=%b en=%b want 00/0", resp_valid, mem_rd_en); end
    req_addr0 = 12'h044; req_addr1 = 12'h055;
    serve(2'b11, 108'h1234, won, ov, od);
    checks++; if (won !== 2'b01 || ov !== 2'b01 || od !== 108'h1234 || mem_addr !== 12'h044) begin errors++; $display("FAIL midreset_serve: got gnt=%b rv=%b data=%h addr=%h want 01/01/1234/044", won, ov, od, mem_addr); end
  endtask
  task automatic test_saturation();
    logic [1:0] won, ov;
    logic [107:0] od;
    force dut.cnt0 = 16'hFFFE;
    #1;
    release dut.cnt0;
    checks++; if (grant_cnt0 !== 16'hFFFE) begin errors++; $display("FAIL sat_preset: got %h want fffe", grant_cnt0); end
    serve(2'b01, 108'h1, won, ov, od);
    checks++; if (grant_cnt0 !== 16'hFFFF) begin errors++; $display("FAIL sat_first: got %h want ffff", grant_cnt0); end
    serve(2'b01, 108'h2, won, ov, od);
    serve(2'b01, 108'h3, won, ov, od);
    checks++; if (grant_cnt0 !== 16'hFFFF || grant_cnt1 !== 16'h0) begin errors++; $display("FAIL sat_hold: got %h/%h want ffff/0000", grant_cnt0, grant_cnt1); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrong_port();
    test_mid_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/input_mem_read_arbiter.md
INPUT_MEM_READ_ARBITER -- requirements
Module: input_mem_read_arbiter

Interface
REQ-001 The block SHALL have parameter ADD_SIZE, default 12, giving the memory address width.
REQ-002 The block SHALL have parameter DATA_SIZE, default 108, giving the memory word width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports req_valid[1:0], input, 2 bits: per-requester read request.
REQ-006 The block SHALL have ports req_addr0 and req_addr1, input, ADD_SIZE each: the requested addresses.
REQ-007 The block SHALL have port req_ready[1:0], output, 2 bits: the request is accepted when it is high together with req_valid.
REQ-008 The block SHALL have port resp_valid[1:0], output, 2 bits: read data is valid for that requester.
REQ-009 The block SHALL have port resp_data, output, DATA_SIZE: shared read data bus, meaningful only when a resp_valid bit is high.
REQ-010 The block SHALL have port resp_ready[1:0], input, 2 bits: the requester accepts the response.
REQ-011 The block SHALL have port mem_rd_en, output, 1 bit: memory read strobe.
REQ-012 The block SHALL have port mem_addr, output, ADD_SIZE: memory read address.
REQ-013 The block SHALL have port mem_rdata, input, DATA_SIZE: memory read data, valid exactly one cycle after mem_rd_en.
REQ-014 The block SHALL have ports grant_cnt0 and grant_cnt1, output, 16 bits each: per-requester grant counters.

Function
REQ-015 The FSM SHALL have four states, IDLE, ISSUE, CAPTURE and RESP, with transitions IDLE->ISSUE on grant, ISSUE->CAPTURE unconditionally, CAPTURE->RESP unconditionally, and RESP->IDLE on resp_ready of the granted requester.
REQ-016 In IDLE with any req_valid high, the block SHALL select one requester, drive its req_ready high combinationally in that same cycle, latch its address and index, and move to ISSUE.
REQ-017 req_ready SHALL be 0 in every state other than IDLE, and SHALL never be high for both requesters at once.
REQ-018 Arbitration SHALL be round-robin via a 1-bit last_grant register: a sole valid requester wins; when both are valid, the requester not equal to last_grant wins; last_grant SHALL update on every grant.
REQ-019 In ISSUE, mem_rd_en SHALL be 1 and mem_addr SHALL equal the latched address; in all other states mem_rd_en SHALL be 0 and mem_addr SHALL hold its last value (no high-Z drive).
REQ-020 In CAPTURE, mem_rdata SHALL be registered into the resp_data register.
REQ-021 In RESP, only the granted requester's resp_valid bit SHALL be high, and resp_data SHALL be stable until resp_ready is high for that requester.
REQ-022 Latency SHALL be fixed: accept at cycle T, mem_rd_en at T+1, data captured at T+2, resp_valid first high at T+3; the earliest next accept SHALL be the cycle after resp_ready.
REQ-023 A resp_ready on the non-granted requester SHALL be ignored, and req_valid changes outside IDLE SHALL be ignored.
REQ-024 On each grant, the winner's grant counter SHALL increment and SHALL saturate at 16'hFFFF (no wrap).

Reset
REQ-025 On rst low, the block SHALL enter IDLE immediately regardless of clock and regardless of any read in flight, which SHALL be abandoned with no response.
REQ-026 Reset values SHALL be: req_ready=0, resp_valid=0, mem_rd_en=0, mem_addr=0, resp_data=0, grant_cnt0/1=0, and last_grant=1 so that requester 0 wins the first contention.

Structure
REQ-027 The state enum type and the requester count constant (2) SHALL reside in the shared package imem_pkg.
REQ-028 Round-robin selection SHALL be a sub-module rr_arb2 (inputs: req[1:0], last; output: one-hot gnt[1:0]).

Verification
REQ-029 Single request: req_valid=01, addr0=0x123 -> mem_rd_en=1 with mem_addr=0x123 at T+1; with mem_rdata=108'hABC at T+2, resp_valid=01 and resp_data=0xABC at T+3.
REQ-030 Contention after reset: req_valid=11 -> grant to 0 first, then 1, alternating 0,1,0,1 over four transactions; grant_cnt0=grant_cnt1=2.
REQ-031 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data held, no new mem_rd_en, and req_ready stays 00.
REQ-032 Mid-operation reset: assert rst=0 in CAPTURE -> all outputs return to reset values asynchronously; after release, a new request is served normally.
REQ-033 Saturation: force grant_cnt0=16'hFFFE, then perform 3 grants to requester 0 -> grant_cnt0=16'hFFFF.
REQ-034 Wrong-port ready: resp_ready=10 while serving requester 0 -> remains in RESP until resp_ready[0]=1.
